// File: rtl/mul_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: ID width helper, issue FSM encoding.
// No ports; imported by mul_tag_fifo and mul_share_arb.
package mul_arb_pkg;

    localparam int NREQ_DFLT = 4;

    // Width of a requester ID; never below 1 bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW = id_w(NREQ_DFLT);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mul_tag_fifo.sv
// Synchronous FIFO of requester-ID tags, DEPTH a power of 2.
// Ports: clk, reset (async active-low), push/din, pop/dout, count, full, empty.
module mul_tag_fifo
    import mul_arb_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  TW    = IDW,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [TW-1:0] din,
    output logic [TW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one in-order pipelined multiplier among NREQ requesters: round-robin grant,
// registered issue (val_op/oprand_rdy), and tag-FIFO routing of commits back to requesters.
// Ports: req_val/req_rdy/req_a/req_b (requesters), resp_val/resp_p (responses),
//   mul_intA/mul_intB/mul_val_op/mul_oprand_rdy/mul_commit/mul_longP (multiplier),
//   busy, err_orphan (status). `MUL_ARB_PERF_EN adds grant_cnt and stall_cnt.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 8,
    parameter int W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_val,
    output logic [NREQ-1:0]    req_rdy,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    output logic [NREQ-1:0]    resp_val,
    output logic [2*W-1:0]     resp_p,
    output logic [W-1:0]       mul_intA,
    output logic [W-1:0]       mul_intB,
    output logic               mul_val_op,
    input  logic               mul_oprand_rdy,
    input  logic               mul_commit,
    input  logic [2*W-1:0]     mul_longP,
    output logic               busy,
`ifdef MUL_ARB_PERF_EN
    output logic [NREQ*16-1:0] grant_cnt,
    output logic [15:0]        stall_cnt,
`endif
    output logic               err_orphan
);

    localparam int TW = id_w(NREQ);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] hi_idx;
    logic [TW-1:0] lo_idx;
    logic [TW-1:0] tag_out;
    logic          hi_hit;
    logic          lo_hit;
    logic          gnt_hit;
    logic          consume;
    logic          can_accept;
    logic          accept;
    logic          pop;
    logic [CW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;

    // Round-robin: lowest valid index above rr_ptr wins, else lowest at or below it.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_val[j]) begin
                if (j > int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = TW'(j);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = TW'(j);
                end
            end
        end
        gnt_hit = hi_hit | lo_hit;
        gnt_idx = hi_hit ? hi_idx : lo_idx;
    end

    // A same-cycle pop gives no credit: full is judged on the pre-pop count.
    assign consume    = (state == HOLD) & mul_oprand_rdy;
    assign can_accept = reset & ((state == IDLE) | consume) & ~tag_full;
    assign accept     = can_accept & gnt_hit;
    assign req_rdy    = accept ? (ONE << gnt_idx) : '0;
    assign pop        = mul_commit & ~tag_empty;
    assign busy       = (tag_count != '0);

    mul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .TW    (TW)
    ) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (gnt_idx),
        .dout  (tag_out),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: if (consume && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_val_op = (state == HOLD);
    end

    // Operands only change on accept, so a stalled op stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_intA <= '0;
            mul_intB <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            mul_intA <= req_a[int'(gnt_idx)*W +: W];
            mul_intB <= req_b[int'(gnt_idx)*W +: W];
            rr_ptr   <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_val   <= '0;
            resp_p     <= '0;
            err_orphan <= 1'b0;
        end else begin
            resp_val <= pop ? (ONE << tag_out) : '0;
            if (pop) begin
                resp_p <= mul_longP;
            end
            if (mul_commit && tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef MUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && gnt_idx == TW'(i) &&
                    grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (state == HOLD && !mul_oprand_rdy && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural in-order multiplier.
// Perf outputs are checked when MUL_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int TAG_DEPTH = 8;
    localparam int W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_val;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   resp_val;
    logic [2*W-1:0]    resp_p;
    logic [W-1:0]      mul_intA;
    logic [W-1:0]      mul_intB;
    logic              mul_val_op;
    logic              mul_oprand_rdy = 1'b0;
    logic              mul_commit = 1'b0;
    logic [2*W-1:0]    mul_longP = '0;
    logic              busy;
    logic              err_orphan;
`ifdef MUL_ARB_PERF_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    bit stall = 1'b0;
    bit commit_en = 1'b1;
    bit orphan_req = 1'b0;
    int issue_cnt = 0;
    int rdy_cnt0 = 0;
    logic [63:0] mq_p[$];
    int          mq_due[$];
    int          grant_log[$];
    int          resp_tag[$];
    logic [63:0] resp_prod[$];

    mul_share_arb #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_p(resp_p),
        .mul_intA(mul_intA), .mul_intB(mul_intB), .mul_val_op(mul_val_op),
        .mul_oprand_rdy(mul_oprand_rdy), .mul_commit(mul_commit), .mul_longP(mul_longP),
        .busy(busy),
`ifdef MUL_ARB_PERF_EN
        .grant_cnt(grant_cnt), .stall_cnt(stall_cnt),
`endif
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model plus grant/response logging, all mid-cycle.
    always @(negedge clk) begin
        logic signed [63:0] sa, sb;
        if (!reset) begin
            mq_p.delete();
            mq_due.delete();
            mul_commit = 1'b0;
            mul_oprand_rdy = 1'b0;
        end else begin
            mul_commit = 1'b0;
            if (orphan_req) begin
                mul_commit = 1'b1;
                mul_longP = 64'h0000_0000_0000_DEAD;
            end else if (commit_en && mq_p.size() > 0 && mq_due[0] <= cyc) begin
                mul_commit = 1'b1;
                mul_longP = mq_p.pop_front();
                void'(mq_due.pop_front());
            end
            mul_oprand_rdy = !stall;
            #1;
            if (mul_val_op && mul_oprand_rdy) begin
                sa = {{32{mul_intA[31]}}, mul_intA};
                sb = {{32{mul_intB[31]}}, mul_intB};
                mq_p.push_back(sa * sb);
                mq_due.push_back(cyc + lat);
                issue_cnt++;
            end
            if (req_rdy[0]) rdy_cnt0++;
            for (int i = 0; i < NREQ; i++)
                if (req_val[i] && req_rdy[i]) grant_log.push_back(i);
            if (resp_val != '0) begin
                case (resp_val)
                    4'b0001: resp_tag.push_back(0);
                    4'b0010: resp_tag.push_back(1);
                    4'b0100: resp_tag.push_back(2);
                    4'b1000: resp_tag.push_back(3);
                    default: resp_tag.push_back(-1);
                endcase
                resp_prod.push_back(resp_p);
            end
        end
    end

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = W'(10 + i);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_val = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL rst_req_rdy: got %b want 0", req_rdy); end
        checks++; if (resp_val !== 4'b0) begin errors++; $display("FAIL rst_resp_val: got %b want 0", resp_val); end
        checks++; if (resp_p !== 64'h0) begin errors++; $display("FAIL rst_resp_p: got %h want 0", resp_p); end
        checks++; if (mul_intA !== 32'h0) begin errors++; $display("FAIL rst_intA: got %h want 0", mul_intA); end
        checks++; if (mul_intB !== 32'h0) begin errors++; $display("FAIL rst_intB: got %h want 0", mul_intB); end
        checks++; if (mul_val_op !== 1'b0) begin errors++; $display("FAIL rst_val_op: got %b want 0", mul_val_op); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b want 0", err_orphan); end
`ifdef MUL_ARB_PERF_EN
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL rst_grant_cnt: got %h want 0", grant_cnt); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
`endif
        reset = 1'b1;
    endtask

    task automatic test_single();
        int g0 = grant_log.size();
        int r0 = resp_tag.size();
        int t;
        rdy_cnt0 = 0;
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd5;
        req_val = 4'b0001;
        for (int k = 0; k < 20 && grant_log.size() == g0; k++) begin
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        req_val = '0;
        t = (grant_log.size() > g0) ? grant_log[g0] : -1;
        checks++; if (t !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", t); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (rdy_cnt0 !== 1) begin errors++; $display("FAIL single_rdy_cycles: got %0d want 1", rdy_cnt0); end
        checks++; if (resp_tag.size() !== r0 + 1) begin errors++; $display("FAIL single_resp_cnt: got %0d want %0d", resp_tag.size() - r0, 1); end
        t = (resp_tag.size() > r0) ? resp_tag[r0] : -1;
        checks++; if (t !== 0) begin errors++; $display("FAIL single_resp_tag: got %0d want 0", t); end
        checks++; if (resp_prod.size() <= r0 || resp_prod[r0] !== 64'd15) begin errors++; $display("FAIL single_resp_p: got %0d want 15", (resp_prod.size() > r0) ? resp_prod[r0] : 64'hX); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
`ifdef MUL_ARB_PERF_EN
        checks++; if (grant_cnt[15:0] !== 16'd1) begin errors++; $display("FAIL single_grant_cnt: got %0d want 1", grant_cnt[15:0]); end
`endif
    endtask

    task automatic test_round_robin();
        int exp_g[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        logic [63:0] prod_of[4] = '{64'd10, 64'd22, 64'd36, 64'd52};
        int g0 = grant_log.size();
        int r0 = resp_tag.size();
        int t;
        logic [63:0] p;
        set_ops();
        req_val = 4'b1111;
        for (int k = 0; k < 40 && grant_log.size() < g0 + 8; k++) begin
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        req_val = '0;
        checks++; if (grant_log.size() !== g0 + 8) begin errors++; $display("FAIL rr_grant_cnt: got %0d want 8", grant_log.size() - g0); end
        for (int i = 0; i < 8; i++) begin
            t = (grant_log.size() > g0 + i) ? grant_log[g0 + i] : -1;
            checks++; if (t !== exp_g[i]) begin errors++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, t, exp_g[i]); end
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (resp_tag.size() !== r0 + 8) begin errors++; $display("FAIL rr_resp_cnt: got %0d want 8", resp_tag.size() - r0); end
        for (int i = 0; i < 8; i++) begin
            t = (resp_tag.size() > r0 + i) ? resp_tag[r0 + i] : -1;
            p = (resp_prod.size() > r0 + i) ? resp_prod[r0 + i] : 64'hX;
            checks++; if (t !== exp_g[i]) begin errors++; $display("FAIL rr_resp_tag_%0d: got %0d want %0d", i, t, exp_g[i]); end
            checks++; if (p !== prod_of[exp_g[i]]) begin errors++; $display("FAIL rr_resp_p_%0d: got %0d want %0d", i, p, prod_of[exp_g[i]]); end
        end
    endtask

    task automatic test_stall();
        int g0 = grant_log.size();
        int r0 = resp_tag.size();
        int i0;
        int t;
`ifdef MUL_ARB_PERF_EN
        logic [15:0] s0 = stall_cnt;
`endif
        req_a[63:32] = 32'd7;
        req_b[63:32] = 32'd9;
        stall = 1'b1;
        req_val = 4'b0010;
        for (int k = 0; k < 20 && grant_log.size() == g0; k++) begin
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        req_val = 4'b0100;
        i0 = issue_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #2;
            checks++; if (mul_intA !== 32'd7) begin errors++; $display("FAIL stall_intA_c%0d: got %0d want 7", c, mul_intA); end
            checks++; if (mul_intB !== 32'd9) begin errors++; $display("FAIL stall_intB_c%0d: got %0d want 9", c, mul_intB); end
            checks++; if (mul_val_op !== 1'b1) begin errors++; $display("FAIL stall_val_op_c%0d: got %b want 1", c, mul_val_op); end
            checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL stall_req_rdy_c%0d: got %b want 0", c, req_rdy); end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        req_val = '0;
        checks++; if (issue_cnt !== i0) begin errors++; $display("FAIL stall_no_issue: got %0d want %0d", issue_cnt, i0); end
        t = (grant_log.size() > g0) ? grant_log[g0] : -1;
        checks++; if (grant_log.size() !== g0 + 1 || t !== 1) begin errors++; $display("FAIL stall_grant: got %0d grants first %0d want 1 grant to 1", grant_log.size() - g0, t); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (issue_cnt !== i0 + 1) begin errors++; $display("FAIL stall_one_issue: got %0d want %0d", issue_cnt - i0, 1); end
        t = (resp_tag.size() > r0) ? resp_tag[r0] : -1;
        checks++; if (resp_tag.size() !== r0 + 1 || t !== 1) begin errors++; $display("FAIL stall_resp_tag: got %0d resps tag %0d want 1 resp tag 1", resp_tag.size() - r0, t); end
        checks++; if (resp_prod.size() <= r0 || resp_prod[r0] !== 64'd63) begin errors++; $display("FAIL stall_resp_p: got %0d want 63", (resp_prod.size() > r0) ? resp_prod[r0] : 64'hX); end
`ifdef MUL_ARB_PERF_EN
        checks++; if (stall_cnt - s0 !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt - s0); end
`endif
    endtask

    task automatic test_full();
        int exp_f[9] = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
        logic [63:0] prod_of[4] = '{64'd10, 64'd22, 64'd36, 64'd52};
        int g0 = grant_log.size();
        int r0 = resp_tag.size();
        int t;
        logic [63:0] p;
        set_ops();
        commit_en = 1'b0;
        req_val = 4'b1111;
        repeat (12) @(posedge clk);
        @(negedge clk); #2;
        checks++; if (grant_log.size() !== g0 + 8) begin errors++; $display("FAIL full_grants: got %0d want 8", grant_log.size() - g0); end
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL full_req_rdy: got %b want 0", req_rdy); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
        checks++; if (mul_val_op !== 1'b0) begin errors++; $display("FAIL full_last_issued: got %b want 0", mul_val_op); end
        @(posedge clk); #1;
        commit_en = 1'b1;
        @(negedge clk); #2;
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL full_pop_no_credit: got %b want 0", req_rdy); end
        @(posedge clk); #1;
        commit_en = 1'b0;
        @(negedge clk); #2;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL full_slot_freed: got %b want 0100", req_rdy); end
        @(posedge clk); #1;
        req_val = '0;
        commit_en = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (resp_tag.size() !== r0 + 9) begin errors++; $display("FAIL full_resp_cnt: got %0d want 9", resp_tag.size() - r0); end
        for (int i = 0; i < 9; i++) begin
            t = (resp_tag.size() > r0 + i) ? resp_tag[r0 + i] : -1;
            p = (resp_prod.size() > r0 + i) ? resp_prod[r0 + i] : 64'hX;
            checks++; if (t !== exp_f[i]) begin errors++; $display("FAIL full_resp_tag_%0d: got %0d want %0d", i, t, exp_f[i]); end
            checks++; if (p !== prod_of[exp_f[i]]) begin errors++; $display("FAIL full_resp_p_%0d: got %0d want %0d", i, p, prod_of[exp_f[i]]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drained_busy: got %b want 0", busy); end
    endtask

    task automatic test_orphan();
        int r0 = resp_tag.size();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_pre: got %b want 0", err_orphan); end
        orphan_req = 1'b1;
        @(posedge clk); #1;
        orphan_req = 1'b0;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
        checks++; if (resp_val !== 4'b0) begin errors++; $display("FAIL orphan_resp_val: got %b want 0", resp_val); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
        checks++; if (resp_tag.size() !== r0) begin errors++; $display("FAIL orphan_no_resp: got %0d resps want 0", resp_tag.size() - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL orphan_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int g0 = grant_log.size();
        int g1;
        int r1;
        int t;
        set_ops();
        req_val = 4'b1111;
        for (int k = 0; k < 20 && grant_log.size() < g0 + 3; k++) begin
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        req_val = '0;
        @(negedge clk); #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b want 1", busy); end
        req_val = 4'b1111;
        reset = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL arst_req_rdy: got %b want 0", req_rdy); end
        checks++; if (resp_val !== 4'b0) begin errors++; $display("FAIL arst_resp_val: got %b want 0", resp_val); end
        checks++; if (resp_p !== 64'h0) begin errors++; $display("FAIL arst_resp_p: got %h want 0", resp_p); end
        checks++; if (mul_intA !== 32'h0) begin errors++; $display("FAIL arst_intA: got %h want 0", mul_intA); end
        checks++; if (mul_intB !== 32'h0) begin errors++; $display("FAIL arst_intB: got %h want 0", mul_intB); end
        checks++; if (mul_val_op !== 1'b0) begin errors++; $display("FAIL arst_val_op: got %b want 0", mul_val_op); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL arst_orphan: got %b want 0", err_orphan); end
        repeat (2) @(posedge clk);
        #1;
        req_val = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        g1 = grant_log.size();
        r1 = resp_tag.size();
        req_a[95:64] = 32'd2;
        req_b[95:64] = 32'hFFFF_FFFF;
        req_val = 4'b0100;
        for (int k = 0; k < 20 && grant_log.size() == g1; k++) begin
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        req_val = '0;
        t = (grant_log.size() > g1) ? grant_log[g1] : -1;
        checks++; if (t !== 2) begin errors++; $display("FAIL post_rst_grant: got %0d want 2", t); end
        repeat (12) @(posedge clk);
        #1;
        t = (resp_tag.size() > r1) ? resp_tag[r1] : -1;
        checks++; if (resp_tag.size() !== r1 + 1 || t !== 2) begin errors++; $display("FAIL post_rst_resp_tag: got %0d resps tag %0d want 1 resp tag 2", resp_tag.size() - r1, t); end
        checks++; if (resp_prod.size() <= r1 || resp_prod[r1] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL post_rst_resp_p: got %h want fffffffffffffffe", (resp_prod.size() > r1) ? resp_prod[r1] : 64'hX); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL post_rst_orphan: got %b want 0", err_orphan); end
    endtask

    initial begin
        reset = 1'b0;
        req_val = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_full();
        test_orphan();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
